// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: word width and RAM8 geometry.
package cpu_pkg;
  localparam int WORD_W      = 16;
  localparam int RAM8_DEPTH  = 8;
  localparam int RAM8_ADDR_W = 3;
endpackage

// File: rtl/dmux8way.sv
// Write-enable decode: a 2-way DMux and an 8-way tree built from it.
module dmux (
  input  logic in,
  input  logic sel,
  output logic a,
  output logic b
);

  assign a = in & ~sel;
  assign b = in &  sel;

endmodule

module dmux8way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic [7:0] out
);

  logic [1:0] half;
  logic [3:0] quarter;

  dmux u_l1 (.in(in), .sel(sel[2]), .a(half[0]), .b(half[1]));

  // Tree index at each level is the address prefix seen so far, MSB first.
  for (genvar i = 0; i < 2; i++) begin : g_l2
    dmux u_l2 (.in(half[i]), .sel(sel[1]), .a(quarter[2*i]), .b(quarter[2*i+1]));
  end

  for (genvar j = 0; j < 4; j++) begin : g_l3
    dmux u_l3 (.in(quarter[j]), .sel(sel[0]), .a(out[2*j]), .b(out[2*j+1]));
  end

endmodule

// File: rtl/mux8way.sv
// Combinational 8-way word selector for the read port.
module mux8way #(
  parameter int WIDTH = 16
) (
  input  logic [7:0][WIDTH-1:0] in,
  input  logic [2:0]            sel,
  output logic [WIDTH-1:0]      out
);

  assign out = in[sel];

endmodule

// File: rtl/word_reg.sv
// WIDTH-bit storage register with load enable and asynchronous active-low clear.
module word_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) data_d = in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign out = data_q;

endmodule

// File: rtl/ram8.sv
// Eight-word register bank: demux-decoded writes, combinational muxed read.
module ram8
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in,
  input  logic                   load,
  input  logic [RAM8_ADDR_W-1:0] address,
  output logic [WIDTH-1:0]       out
);

  logic [RAM8_DEPTH-1:0]            we;
  logic [RAM8_DEPTH-1:0][WIDTH-1:0] word;

  dmux8way u_dmux (
    .in  (load),
    .sel (address),
    .out (we)
  );

  for (genvar k = 0; k < RAM8_DEPTH; k++) begin : g_word
    word_reg #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (we[k]),
      .in    (in),
      .out   (word[k])
    );
  end

  // Read taps the register outputs, so a same-cycle write shows the old word.
  mux8way #(.WIDTH(WIDTH)) u_mux (
    .in  (word),
    .sel (address),
    .out (out)
  );

endmodule

// File: tb/tb_ram8.sv
// Directed-vector bench for ram8 with hand-computed expected read values.
`timescale 1ns/1ps
module tb_ram8;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        load;
  logic [2:0]  address;
  logic [15:0] dout;

  int vec_cnt;
  int err_cnt;

  ram8 #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (din),
    .load    (load),
    .address (address),
    .out     (dout)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
    address = a;
    #1;
    chk($sformatf("%s[%0d]", tag, a), dout, exp);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b1;
    load    = 1'b0;
    din     = '0;
    address = '0;

    // Reset asserted mid-cycle with a write pending; held across edges.
    #7;
    load  = 1'b1;
    din   = 16'hFFFF;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int a = 0; a < 8; a++) rd("rst_held", 3'(a), 16'h0000);
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b1;

    // Single write to address 3.
    @(negedge clk);
    address = 3'd3;
    din     = 16'h1234;
    load    = 1'b1;
    #1;
    chk("wr3_before", dout, 16'h0000);
    @(posedge clk);
    #1;
    load = 1'b0;
    chk("wr3_after", dout, 16'h1234);
    for (int a = 0; a < 8; a++)
      if (a != 3) rd("wr3_other", 3'(a), 16'h0000);

    // Fill on consecutive edges, then sweep.
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      din     = 16'h1000 + 16'(k);
      load    = 1'b1;
      @(negedge clk);
    end
    load = 1'b0;
    for (int a = 0; a < 8; a++) rd("fill", 3'(a), 16'h1000 + 16'(a));

    // Hold: load low across 4 edges.
    @(negedge clk);
    address = 3'd5;
    din     = 16'hDEAD;
    load    = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("hold5", dout, 16'h1005);

    // Overwrite address 7 on consecutive edges.
    @(negedge clk);
    address = 3'd7;
    din     = 16'hAAAA;
    load    = 1'b1;
    @(posedge clk);
    #1;
    chk("ovw_first", dout, 16'hAAAA);
    @(negedge clk);
    din = 16'h5555;
    @(posedge clk);
    #1;
    chk("ovw_second", dout, 16'h5555);
    @(negedge clk);
    load = 1'b0;
    rd("ovw_neighbor", 3'd6, 16'h1006);

    // Reset pulse between edges discards a pending write.
    @(negedge clk);
    address = 3'd1;
    din     = 16'hBEEF;
    load    = 1'b1;
    #2;
    rst_n = 1'b0;
    #2;
    chk("rst_pulse_out", dout, 16'h0000);
    #2;
    rst_n   = 1'b1;
    address = 3'd2;
    din     = 16'h0042;
    @(posedge clk);
    #1;
    load = 1'b0;
    for (int a = 0; a < 8; a++)
      rd("post_rst", 3'(a), (a == 2) ? 16'h0042 : 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
